// File: rtl/result_frame_decoder_pkg.sv
// Shared result-frame layout constants, used by both the decoder and the UART transmit side.
package result_frame_decoder_pkg;

  localparam int FRAME_BYTES = 64;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;

  localparam logic [63:0] FRAME_TRAILER = 64'hdead432987beefaa;
  localparam logic [7:0]  FRAME_MARKER  = 8'haa;

  // Bit offsets inside the frame; byte k occupies bits [8k+7:8k].
  localparam int HASH_LSB     = 0;
  localparam int HASH_BITS    = 256;
  localparam int MARKER_A_LSB = 256;
  localparam int NONCE_LSB    = 264;
  localparam int NONCE_BITS   = 32;
  localparam int MARKER_B_LSB = 296;
  localparam int TRAILER_LSB  = 448;
  localparam int TRAILER_BITS = 64;
  localparam int DIFF_LSB     = 232;
  localparam int DIFF_BITS    = 24;

  typedef enum logic {
    HUNT = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/result_frame_decoder_if.sv
// Decoded-frame output channel: hash/nonce presented under a valid/ready handshake.
interface result_frame_decoder_if;
  import result_frame_decoder_pkg::*;

  logic [HASH_BITS-1:0]  out_hash;
  logic [NONCE_BITS-1:0] out_nonce;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_hash,
    output out_nonce,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_hash,
    input  out_nonce,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/result_frame_checker.sv
// Combinational trailer/marker compare of a candidate frame window.
// RESULT_DIFF_CHECK_EN adds a leading-zero difficulty check on hash[255:232].
module result_frame_checker
  import result_frame_decoder_pkg::*;
(
  input  logic [TRAILER_BITS-1:0] trailer,
  input  logic [7:0]              marker_a,
  input  logic [7:0]              marker_b,
`ifdef RESULT_DIFF_CHECK_EN
  input  logic [DIFF_BITS-1:0]    diff,
`endif
  output logic                    frame_good,
  output logic                    frame_bad
);

  logic trailer_ok;
  logic body_ok;

  assign trailer_ok = (trailer == FRAME_TRAILER);

`ifdef RESULT_DIFF_CHECK_EN
  assign body_ok = (marker_a == FRAME_MARKER) && (marker_b == FRAME_MARKER) && (diff == '0);
`else
  assign body_ok = (marker_a == FRAME_MARKER) && (marker_b == FRAME_MARKER);
`endif

  // A trailer hit always ends the frame; the body decides good versus rejected.
  assign frame_good = trailer_ok && body_ok;
  assign frame_bad  = trailer_ok && !body_ok;

endmodule

// File: rtl/result_frame_decoder.sv
// Sliding-window decoder for the 64-byte miner result frame, with idle-timeout resync.
// Optional macro RESULT_DIFF_CHECK_EN enables the difficulty check in result_frame_checker.
module result_frame_decoder
  import result_frame_decoder_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 20000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  result_frame_decoder_if.master    frame_out,
  output logic [CNT_WIDTH-1:0]      frame_count,
  output logic [CNT_WIDTH-1:0]      err_count
);

  localparam int                   IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [6:0]           CNT_FULL = 7'(FRAME_BYTES);
  localparam logic [6:0]           CNT_LAST = 7'(FRAME_BYTES - 1);
  localparam logic [CNT_WIDTH-1:0] ERR_SAT  = '1;

  logic [FRAME_BITS-1:0] window;
  logic [FRAME_BITS-1:0] window_next;
  logic [6:0]            byte_cnt;
  logic [IDLE_W-1:0]     idle_cnt;
  state_e                state;

  logic check_en;
  logic chk_good;
  logic chk_bad;
  logic frame_good;
  logic frame_bad;
  logic trailer_hit;
  logic can_load;
  logic idle_expired;

  // The check looks at the window as it will be after this byte shifts in.
  assign window_next = {in_byte, window[FRAME_BITS-1:8]};
  assign check_en    = in_valid && ((state == FULL) || (byte_cnt == CNT_LAST));
  assign frame_good  = check_en && chk_good;
  assign frame_bad   = check_en && chk_bad;
  assign trailer_hit = frame_good || frame_bad;
  assign can_load    = !frame_out.out_valid || frame_out.out_ready;
  assign idle_expired = !in_valid && (idle_cnt == IDLE_MAX) && (byte_cnt != '0);

  result_frame_checker u_checker (
    .trailer    (window_next[TRAILER_LSB +: TRAILER_BITS]),
    .marker_a   (window_next[MARKER_A_LSB +: 8]),
    .marker_b   (window_next[MARKER_B_LSB +: 8]),
`ifdef RESULT_DIFF_CHECK_EN
    .diff       (window_next[DIFF_LSB +: DIFF_BITS]),
`endif
    .frame_good (chk_good),
    .frame_bad  (chk_bad)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // mixing in blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window              <= '0;
      byte_cnt            <= '0;
      idle_cnt            <= '0;
      state               <= HUNT;
      frame_out.out_valid <= 1'b0;
      frame_out.out_hash  <= '0;
      frame_out.out_nonce <= '0;
      frame_count         <= '0;
      err_count           <= '0;
    end else begin
      if (in_valid) begin
        window   <= window_next;
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      case (state)
        HUNT: begin
          if (trailer_hit || idle_expired) begin
            byte_cnt <= '0;
          end else if (in_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == CNT_LAST) state <= FULL;
          end
        end
        FULL: begin
          // byte_cnt stays saturated at a full frame while sliding.
          if (trailer_hit || idle_expired) begin
            byte_cnt <= '0;
            state    <= HUNT;
          end else begin
            byte_cnt <= CNT_FULL;
          end
        end
        default: begin
          byte_cnt <= '0;
          state    <= HUNT;
        end
      endcase

      if (frame_good && can_load) begin
        frame_out.out_hash  <= window_next[HASH_LSB +: HASH_BITS];
        frame_out.out_nonce <= window_next[NONCE_LSB +: NONCE_BITS];
        frame_out.out_valid <= 1'b1;
        frame_count         <= frame_count + 1'b1;
      end else if (frame_out.out_valid && frame_out.out_ready) begin
        frame_out.out_valid <= 1'b0;
      end

      // Rejected frames and good frames dropped behind a stalled consumer both count.
      if ((frame_bad || (frame_good && !can_load)) && (err_count != ERR_SAT)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_frame_decoder.sv
// Directed scoreboard bench for result_frame_decoder.
module tb_result_frame_decoder;

  localparam int IDLE_TIMEOUT = 20000;
  localparam int CNT_WIDTH    = 16;

  typedef struct packed {
    logic [255:0] hash;
    logic [31:0]  nonce;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           in_byte;
  logic                 in_valid;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [CNT_WIDTH-1:0] err_count;

  result_frame_decoder_if dif ();

  result_frame_decoder #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .frame_out   (dif),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] make_frame(input logic [255:0] hash, input logic [31:0] nonce,
                                              input logic [7:0] ma, input logic [7:0] mb);
    logic [511:0] f;
    f            = '0;
    f[255:0]     = hash;
    f[263:256]   = ma;
    f[295:264]   = nonce;
    f[303:296]   = mb;
    f[447:304]   = {18{8'h3c}};
    f[511:448]   = 64'hdead432987beefaa;
    return f;
  endfunction

  task automatic do_reset();
    in_valid      = 1'b0;
    in_byte       = 8'h00;
    dif.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic send_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [511:0] f, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(f[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consume(input string tag);
    exp_t e;
    int   w;
    w = 0;
    while (!dif.out_valid && w < 8) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({tag, " out_valid"}, 256'(dif.out_valid), 256'(1));
    check({tag, " sb_nonempty"}, 256'(sb.size() != 0), 256'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " out_hash"},  dif.out_hash, e.hash);
      check({tag, " out_nonce"}, 256'(dif.out_nonce), 256'(e.nonce));
    end
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    check({tag, " valid_fall"}, 256'(dif.out_valid), 256'(0));
  endtask

  logic [255:0] h1, h2, h3;
  logic [31:0]  n1, n2;
  logic [511:0] fa, fb, fbad, fdiff;

  initial begin
    h1    = 256'h00000012_3456789a_bcdef012_3456789a_bcdef012_3456789a_bcdef012_3456789a;
    h2    = 256'h00000000_11112222_33334444_55556666_77778888_9999aaaa_bbbbcccc_ddddeeee;
    h3    = {24'h000100, 232'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00ab};
    n1    = 32'hb2957c02;
    n2    = 32'h0badf00d;
    fa    = make_frame(h1, n1, 8'haa, 8'haa);
    fb    = make_frame(h2, n2, 8'haa, 8'haa);
    fbad  = make_frame(h2, n2, 8'haa, 8'h55);
    fdiff = make_frame(h3, n2, 8'haa, 8'haa);

    // Reset state.
    do_reset();
    check("rst out_valid",   256'(dif.out_valid), 256'(0));
    check("rst out_hash",    dif.out_hash, 256'(0));
    check("rst out_nonce",   256'(dif.out_nonce), 256'(0));
    check("rst frame_count", 256'(frame_count), 256'(0));
    check("rst err_count",   256'(err_count), 256'(0));

    // Clean frame: output one cycle after the last byte.
    sb.push_back('{hash: h1, nonce: n1});
    send_frame(fa, 0, 63);
    check("f1 latency valid", 256'(dif.out_valid), 256'(1));
    check("f1 frame_count",   256'(frame_count), 256'(1));
    consume("f1");

    // Garbage prefix before the frame.
    do_reset();
    repeat (5) send_byte(8'h11);
    sb.push_back('{hash: h2, nonce: n2});
    send_frame(fb, 0, 63);
    consume("garbage");
    check("garbage frame_count", 256'(frame_count), 256'(1));
    check("garbage err_count",   256'(err_count), 256'(0));

    // Reset in the middle of a frame.
    send_frame(fa, 0, 19);
    do_reset();
    sb.push_back('{hash: h1, nonce: n1});
    send_frame(fa, 0, 63);
    consume("midreset");
    check("midreset frame_count", 256'(frame_count), 256'(1));

    // Bad marker, then an immediately following good frame.
    do_reset();
    send_frame(fbad, 0, 63);
    check("badmk out_valid", 256'(dif.out_valid), 256'(0));
    check("badmk err_count", 256'(err_count), 256'(1));
    sb.push_back('{hash: h1, nonce: n1});
    send_frame(fa, 0, 63);
    consume("after_bad");
    check("after_bad frame_count", 256'(frame_count), 256'(1));

    // Stalled consumer: second good frame dropped, first held.
    do_reset();
    sb.push_back('{hash: h1, nonce: n1});
    send_frame(fa, 0, 63);
    send_frame(fb, 0, 63);
    check("stall err_count",   256'(err_count), 256'(1));
    check("stall frame_count", 256'(frame_count), 256'(1));
    check("stall held hash",   dif.out_hash, h1);
    consume("stall");

    // Idle gap longer than the timeout discards the partial frame.
    do_reset();
    send_frame(fa, 0, 29);
    idle(IDLE_TIMEOUT + 1);
    send_frame(fa, 30, 63);
    check("timeout out_valid",   256'(dif.out_valid), 256'(0));
    check("timeout frame_count", 256'(frame_count), 256'(0));
    check("timeout err_count",   256'(err_count), 256'(0));
    sb.push_back('{hash: h1, nonce: n1});
    send_frame(fa, 0, 63);
    consume("timeout");
    check("timeout final frame_count", 256'(frame_count), 256'(1));

    // Gap shorter than the timeout keeps the partial frame.
    do_reset();
    send_frame(fb, 0, 29);
    idle(IDLE_TIMEOUT - 1);
    sb.push_back('{hash: h2, nonce: n2});
    send_frame(fb, 30, 63);
    consume("short_gap");
    check("short_gap frame_count", 256'(frame_count), 256'(1));

    // Nonzero difficulty bits in hash[255:232].
    do_reset();
`ifdef RESULT_DIFF_CHECK_EN
    send_frame(fdiff, 0, 63);
    check("diff out_valid",   256'(dif.out_valid), 256'(0));
    check("diff err_count",   256'(err_count), 256'(1));
    check("diff frame_count", 256'(frame_count), 256'(0));
`else
    sb.push_back('{hash: h3, nonce: n2});
    send_frame(fdiff, 0, 63);
    consume("diff");
    check("diff err_count",   256'(err_count), 256'(0));
    check("diff frame_count", 256'(frame_count), 256'(1));
`endif

    check("sb drained", 256'(sb.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
